alu_seq_mc: RTL
===============

Name: alu_seq_mc

Overview:
- Parametrised, multi-cycle successor to the team's 8-bit clocked ALU.
- Adds a valid/ready handshake on both sides, registered status flags and variable-amount shifts.
- Adds an iterative unsigned multiplier.
- Sits between the operand/opcode source and the result sink. Holds one operation in flight at a time.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, power of 2)
SHW, $clog2(WIDTH), width of the shift-amount field taken from b[SHW-1:0]

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands/opcode present
in_ready  output  1  block can accept (IDLE and rst low)
a  input  WIDTH  operand A
b  input  WIDTH  operand B (shift amount = b[SHW-1:0])
op  input  4  opcode
out_valid  output  1  result valid, held until accepted
out_ready  input  1  sink accepts result
res  output  WIDTH  result (low half for MUL)
res_hi  output  WIDTH  MUL high half, 0 for all other ops
carry  output  1  carry / borrow / last bit shifted out
zero  output  1  result (full product for MUL) == 0
neg  output  1  res[WIDTH-1]
ovf  output  1  signed overflow (ADD/SUB only, else 0)
err  output  1  illegal opcode

Behaviour:
- Reset (async, asserted): state=IDLE; res, res_hi, all flags and out_valid = 0; counters cleared; in_ready=0 while rst high.
- Reset mid-operation aborts the op with no partial output.
- FSM states: IDLE, EXEC, DONE.
- IDLE: in_ready=1. If in_valid is high at an edge, a/b/op are latched and the state goes to EXEC.
- EXEC: in_ready=0. Stays for N cycles, then registers the result and flags and goes to DONE.
- DONE: out_valid=1; res and flags stable. On an edge with out_ready=1, go to IDLE.
- Throughput: in_valid during EXEC/DONE is ignored. The earliest next accept is the cycle after the DONE handshake.
- N=1 for ops 0,1,2,5,6,7,8 and illegal ops. out_valid rises at the 2nd edge after accept.
- N=max(n,1) for shifts, where n=b[SHW-1:0]. Shifts move one bit per cycle.
- N=WIDTH for MUL: shift-add, one multiplier bit per cycle.
- Opcodes:
  - 0 ADD: res=a+b; carry=unsigned carry-out; ovf=signed overflow.
  - 1 SUB: res=a-b (two's complement); carry=borrow (1 iff a<b unsigned); ovf=signed overflow.
  - 2 PASS: res=a.
  - 3 SHL: res=a<<n; carry=last bit shifted out; carry=0 if n=0.
  - 4 SHR: logical right shift, res=a>>n; carry as SHL.
  - 5 AND: res=a&b.
  - 6 NOT: res=~a.
  - 7 OR: res=a|b.
  - 8 XOR: res=a^b.
  - 9 SAR: arithmetic right shift by n, sign fill; carry as SHL.
  - 10 MUL: {res_hi,res}=a*b unsigned; carry=(res_hi!=0).
  - 11-15: illegal; res=0, err=1, zero=1, other flags 0.
- Flags apply to ADD/SUB/shift/MUL as defined above. For logic/PASS ops, carry=ovf=0.
- zero and neg are computed for every op. err=0 for legal ops.
- Outputs change only on the EXEC->DONE edge or on reset. Outputs hold their last values through IDLE; out_valid is the only qualifier.
- Width rules:
  - Internal adder is WIDTH+1 bits.
  - Multiplier accumulator is 2*WIDTH bits.
  - The shift counter is SHW bits and counts down to 0.
  - A shift amount >= WIDTH is impossible by construction (n < WIDTH).

Test Plan:
- WIDTH=8, ADD a=255 b=20 -> res=19, carry=1, zero=0, ovf=0; out_valid 2 edges after accept.
- SUB a=5 b=7 -> res=254, carry=1, neg=1, ovf=0. SUB a=128 b=1 -> res=127, ovf=1.
- MUL a=200 b=3 -> res_hi=2, res=88, carry=1; out_valid exactly 9 edges after accept (8 EXEC + 1). MUL a=0 b=77 -> zero=1.
- SHL a=255 b=3 -> res=248, carry=1, out_valid after 4 edges. SHR a=123 b=0 -> res=123, carry=0, 1 EXEC cycle. SAR a=0x90 b=2 -> 0xE4.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 and new a/b -> res and flags stable, in_ready=0, second op not accepted. Raise out_ready -> IDLE, then the second op is accepted and computed.
- rst pulsed for 1 cycle mid-MUL (cycle 4) -> out_valid=0, res=0 immediately. A following op=12 -> res=0, err=1, zero=1.

Source files
------------

// File: rtl/alu_seq_mc.sv
// Multi-cycle ALU with valid/ready handshakes, registered flags, bit-serial shifts
// and a shift-add unsigned multiplier. One operation in flight at a time.
module alu_seq_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_PASS = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_SAR  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;

  logic [1:0]         state_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, work_reg;
  logic [3:0]         op_reg;
  logic [SHW-1:0]     cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;

  logic [WIDTH:0]     sum_w, diff_w, mul_sum;
  logic [WIDTH-1:0]   shift_next, addend;
  logic               shift_out;
  logic [2*WIDTH-1:0] acc_next;

  logic               last;
  logic [WIDTH-1:0]   r_res, r_hi;
  logic               r_carry, r_ovf, r_err;

  assign in_ready = (state_reg == IDLE) && !rst;

  assign sum_w  = {1'b0, a_reg} + {1'b0, b_reg};
  assign diff_w = {1'b0, a_reg} - {1'b0, b_reg};

  // Multiplier: acc = {partial product high half, remaining multiplier bits}
  assign addend   = acc_reg[0] ? a_reg : '0;
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_next = {mul_sum, acc_reg[WIDTH-1:1]};

  always_comb begin
    shift_next = {1'b0, work_reg[WIDTH-1:1]};
    shift_out  = work_reg[0];
    case (op_reg)
      OP_SHL: begin
        shift_next = {work_reg[WIDTH-2:0], 1'b0};
        shift_out  = work_reg[WIDTH-1];
      end
      OP_SAR: shift_next = {work_reg[WIDTH-1], work_reg[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_comb begin
    last    = 1'b1;
    r_res   = '0;
    r_hi    = '0;
    r_carry = 1'b0;
    r_ovf   = 1'b0;
    r_err   = 1'b0;
    case (op_reg)
      OP_ADD: begin
        r_res   = sum_w[WIDTH-1:0];
        r_carry = sum_w[WIDTH];
        r_ovf   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (sum_w[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_SUB: begin
        r_res   = diff_w[WIDTH-1:0];
        r_carry = diff_w[WIDTH];
        r_ovf   = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (diff_w[WIDTH-1] != a_reg[WIDTH-1]);
      end
      OP_PASS: r_res = a_reg;
      OP_AND:  r_res = a_reg & b_reg;
      OP_NOT:  r_res = ~a_reg;
      OP_OR:   r_res = a_reg | b_reg;
      OP_XOR:  r_res = a_reg ^ b_reg;
      OP_SHL, OP_SHR, OP_SAR: begin
        // A zero shift amount still spends one cycle and shifts nothing
        last    = (cnt_reg <= SHW'(1));
        r_res   = (cnt_reg == '0) ? work_reg : shift_next;
        r_carry = (cnt_reg != '0) && shift_out;
      end
      OP_MUL: begin
        last    = (cnt_reg == '0);
        r_res   = acc_next[WIDTH-1:0];
        r_hi    = acc_next[2*WIDTH-1:WIDTH];
        r_carry = |acc_next[2*WIDTH-1:WIDTH];
      end
      default: r_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      work_reg  <= '0;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      out_valid <= 1'b0;
      res       <= '0;
      res_hi    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            op_reg    <= op;
            work_reg  <= a;
            acc_reg   <= {{WIDTH{1'b0}}, b};
            cnt_reg   <= (op == OP_MUL) ? SHW'(WIDTH - 1) : b[SHW-1:0];
            state_reg <= EXEC;
          end
        end
        EXEC: begin
          acc_reg <= acc_next;
          if (cnt_reg != '0) begin
            work_reg <= shift_next;
            cnt_reg  <= cnt_reg - SHW'(1);
          end
          if (last) begin
            res       <= r_res;
            res_hi    <= r_hi;
            carry     <= r_carry;
            zero      <= ~|{r_hi, r_res};
            neg       <= r_res[WIDTH-1];
            ovf       <= r_ovf;
            err       <= r_err;
            out_valid <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
